hdr_gain_crossfader: RTL and testbench



---
 rtl/hdr_gain_crossfader.sv | 126 ++++++++++++
 tb/tb_hdr_gain_crossfader.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/hdr_gain_crossfader.sv
// Merges the HG and LG HDR sample streams into one LG-scaled stream, switching paths with a
// linear N-sample crossfade driven by the alpha gain-select request.
module hdr_gain_crossfader #(
  parameter int unsigned DATA_W       = 9,
  parameter int unsigned GAIN_SHIFT   = 4,
  parameter int unsigned FADE_LOG2    = 3,
  parameter int unsigned HOLD_SAMPLES = 16
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                enable_sampling,
  input  logic                                alpha,
  input  logic signed [DATA_W-1:0]            hg_sample,
  input  logic signed [DATA_W-1:0]            lg_sample,
  output logic signed [DATA_W+GAIN_SHIFT-1:0] combined_sample,
  output logic                                combined_valid,
  output logic                                active_gain,
  output logic                                fading
);

  localparam int unsigned OutW    = DATA_W + GAIN_SHIFT;
  localparam int unsigned MixW    = OutW + FADE_LOG2 + 2;
  localparam int unsigned KW      = FADE_LOG2 + 1;
  localparam int unsigned FadeLen = 1 << FADE_LOG2;
  localparam int unsigned HoldW   = (HOLD_SAMPLES > 0) ? $clog2(HOLD_SAMPLES + 1) : 1;

  localparam logic [KW-1:0]    KFull   = KW'(FadeLen);
  localparam logic [HoldW-1:0] HoldMax = HoldW'(HOLD_SAMPLES);

  typedef enum logic [1:0] {StHg, StFadeUp, StLg, StFadeDn} state_e;

  state_e             state_q, state_d;
  logic [KW-1:0]      k_q, k_d;
  logic [HoldW-1:0]   hold_q, hold_d;

  logic               go_up, go_down;
  logic [KW-1:0]      k_up, k_dn;

  logic signed [MixW-1:0] hg_ext, lg_ext, w_hg, w_lg, mix_sum, mix_full;
  logic signed [OutW-1:0] mix;
  logic                   active_gain_d, fading_d;

  // State register and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= StHg;
      k_q             <= '0;
      hold_q          <= '0;
      combined_sample <= '0;
      combined_valid  <= 1'b0;
      active_gain     <= 1'b0;
      fading          <= 1'b0;
    end else begin
      state_q        <= state_d;
      k_q            <= k_d;
      hold_q         <= hold_d;
      combined_valid <= enable_sampling;
      if (enable_sampling) begin
        combined_sample <= mix;
        active_gain     <= active_gain_d;
        fading          <= fading_d;
      end
    end
  end

  assign k_up = k_q + KW'(1);
  assign k_dn = k_q - KW'(1);

  // Next-state: a fade in either direction simply follows alpha from the current k
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    hold_d  = hold_q;
    go_up   = 1'b0;
    go_down = 1'b0;
    if (enable_sampling) begin
      unique case (state_q)
        StHg: go_up = alpha;
        StFadeUp, StFadeDn: begin
          go_up   = alpha;
          go_down = !alpha;
        end
        StLg: begin
          if (!alpha && (hold_q == HoldMax)) begin
            go_down = 1'b1;
          end else if (hold_q != HoldMax) begin
            hold_d = hold_q + HoldW'(1);
          end
        end
        default: state_d = StHg;
      endcase
      if (go_up) begin
        k_d = k_up;
        if (k_up == KFull) begin
          state_d = StLg;
          hold_d  = '0;
        end else begin
          state_d = StFadeUp;
        end
      end else if (go_down) begin
        k_d     = k_dn;
        state_d = (k_dn == '0) ? StHg : StFadeDn;
      end
    end
  end

  // Output: weighted mix with the pre-update k; arithmetic shift gives floor rounding
  always_comb begin
    hg_ext   = MixW'(hg_sample);
    lg_ext   = MixW'(lg_sample) <<< GAIN_SHIFT;
    w_lg     = MixW'(k_q);
    w_hg     = MixW'(KFull - k_q);
    mix_sum  = (hg_ext * w_hg) + (lg_ext * w_lg);
    mix_full = mix_sum >>> FADE_LOG2;
    mix      = mix_full[OutW-1:0];

    active_gain_d = active_gain;
    if (state_d == StLg) begin
      active_gain_d = 1'b1;
    end else if (state_d == StHg) begin
      active_gain_d = 1'b0;
    end
    fading_d = (state_d == StFadeUp) || (state_d == StFadeDn);
  end

endmodule

// File: tb/tb_hdr_gain_crossfader.sv
// Self-checking bench for hdr_gain_crossfader: directed scenarios plus randomized traffic,
// all checked against an arithmetic reference model of the crossfade position k.
module tb_hdr_gain_crossfader;

  localparam int DataW = 9;
  localparam int GainShift = 4;
  localparam int FadeLog2 = 3;
  localparam int HoldSamples = 16;
  localparam int FadeLen = 1 << FadeLog2;

  logic                         clk = 1'b0;
  logic                         reset;
  logic                         enable_sampling;
  logic                         alpha;
  logic signed [DataW-1:0]      hg_sample;
  logic signed [DataW-1:0]      lg_sample;
  logic signed [DataW+GainShift-1:0] combined_sample;
  logic                         combined_valid;
  logic                         active_gain;
  logic                         fading;

  int n_checks = 0;
  int n_fail = 0;

  // Reference model: position k in [0,N] fully determines HG/fade/LG; hold counted separately
  int m_k, m_hold;
  int exp_sample, exp_valid, exp_ag, exp_fading;

  hdr_gain_crossfader #(
    .DATA_W      (DataW),
    .GAIN_SHIFT  (GainShift),
    .FADE_LOG2   (FadeLog2),
    .HOLD_SAMPLES(HoldSamples)
  ) u_dut (
    .clk            (clk),
    .reset          (reset),
    .enable_sampling(enable_sampling),
    .alpha          (alpha),
    .hg_sample      (hg_sample),
    .lg_sample      (lg_sample),
    .combined_sample(combined_sample),
    .combined_valid (combined_valid),
    .active_gain    (active_gain),
    .fading         (fading)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic int floor_div(input int a, input int b);
    int q;
    q = a / b;
    if ((a % b != 0) && (a < 0)) q--;
    return q;
  endfunction

  task automatic model_step(input bit rst, input bit strobe, input bit a, input int hg,
                            input int lg);
    if (rst) begin
      m_k = 0; m_hold = 0;
      exp_sample = 0; exp_valid = 0; exp_ag = 0; exp_fading = 0;
      return;
    end
    exp_valid = strobe;
    if (!strobe) return;
    exp_sample = floor_div(hg * (FadeLen - m_k) + lg * (1 << GainShift) * m_k, FadeLen);
    if (m_k == FadeLen) begin
      if (!a && m_hold == HoldSamples) m_k = FadeLen - 1;
      else if (m_hold < HoldSamples) m_hold++;
    end else if (a) begin
      m_k++;
      if (m_k == FadeLen) m_hold = 0;
    end else if (m_k > 0) begin
      m_k--;
    end
    exp_fading = (m_k > 0 && m_k < FadeLen) ? 1 : 0;
    if (m_k == FadeLen) exp_ag = 1;
    if (m_k == 0) exp_ag = 0;
  endtask

  // One clock: drive, clock, advance the model, compare every output
  task automatic step(input bit rst, input bit strobe, input bit a, input int hg, input int lg);
    reset = rst;
    enable_sampling = strobe;
    alpha = a;
    hg_sample = DataW'(hg);
    lg_sample = DataW'(lg);
    @(posedge clk);
    #1;
    model_step(rst, strobe, a, hg, lg);
    check("valid", int'(combined_valid), exp_valid);
    check("sample", int'(combined_sample), exp_sample);
    check("active_gain", int'(active_gain), exp_ag);
    check("fading", int'(fading), exp_fading);
  endtask

  initial begin
    int hg, lg;
    bit a;
    m_k = 0; m_hold = 0;
    exp_sample = 0; exp_valid = 0; exp_ag = 0; exp_fading = 0;

    step(1, 0, 0, 0, 0);
    step(1, 1, 1, 55, 7);
    check("rst_sample", int'(combined_sample), 0);
    check("rst_valid", int'(combined_valid), 0);

    // T1 HG settled
    step(0, 1, 0, 100, 5);
    check("t1_sample", int'(combined_sample), 100);
    check("t1_gain", int'(active_gain), 0);

    // T2 upswing
    for (int i = 0; i < 9; i++) begin
      step(0, 1, 1, 80, 10);
      check("t2_out", int'(combined_sample), 80 + 10 * i);
      check("t2_fading", int'(fading), (i < 7) ? 1 : 0);
      check("t2_gain", int'(active_gain), (i == 7 || i == 8) ? 1 : 0);
    end

    // T3 floor rounding at k=4
    step(1, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) step(0, 1, 1, -1, 0);
    check("t3_floor", int'(combined_sample), -1);

    // T4 hold in LG before the down-fade
    step(1, 0, 0, 0, 0);
    for (int i = 0; i < 8; i++) step(0, 1, 1, 3, 3);
    for (int i = 1; i <= 24; i++) begin
      step(0, 1, 0, 3, 3);
      check("t4_fading", int'(fading), (i >= 17 && i <= 23) ? 1 : 0);
      check("t4_gain", int'(active_gain), (i < 24) ? 1 : 0);
    end

    // T5 reversal mid-fade, then immediate upswing from HG
    step(1, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 1, 1, 0, 8);
    for (int i = 0; i < 3; i++) begin
      step(0, 1, 0, 0, 8);
      check("t5_weight", int'(combined_sample), 16 * (3 - i));
    end
    check("t5_settled", int'(fading), 0);
    step(0, 1, 1, 0, 8);
    check("t5_reup", int'(fading), 1);

    // T6 sparse strobes, then reset mid-fade at k=5
    step(1, 0, 0, 0, 0);
    for (int i = 0; i < 20; i++) step(0, (i % 4) == 0, 1, 40 + i, -20 + i);
    check("t6_midfade", int'(fading), 1);
    step(1, 0, 1, 0, 0);
    check("t6_rst_sample", int'(combined_sample), 0);
    check("t6_rst_fading", int'(fading), 0);
    check("t6_rst_gain", int'(active_gain), 0);

    // Randomized traffic with sticky alpha and occasional resets
    a = 0;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 9) == 0) a = ~a;
      hg = int'($urandom_range(0, 511)) - 256;
      lg = int'($urandom_range(0, 511)) - 256;
      step($urandom_range(0, 499) == 0, $urandom_range(0, 2) != 0, a, hg, lg);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
